spdif_tx_sched: RTL and testbench
=================================

// Module: spdif_tx_sched
// PURPOSE
//  Sequencer feeding the SPDIF TX core. Buffers stereo PCM pairs from the audio source in a small FIFO.
//  Answers the TX core's per-subframe requests for audio, validity, user and channel-status bits.
//  Keeps the 192-frame channel-status index aligned to the TX block start.
//  On FIFO underrun it substitutes muted frames flagged invalid.
//  Sits between the audio source and SPDIF_TX_Top, in the TX clock domain.
// PARAMETERS
//  DATA_WIDTH    24  PCM sample width; samples narrower than 24 bits are MSB-aligned by the source.
//  FIFO_DEPTH    4   Number of stereo pairs buffered; power of 2, >=2.
//  CS_BITS       24  Number of channel-status bits taken from I_cs_cfg; bits CS_BITS..191 transmit as 0.
//  USER_BIT_VAL  0   Constant user bit.
// PORTS
//  I_clk                  in   1           TX clock; the only clock.
//  I_rst                  in   1           Synchronous, active-high reset.
//  I_enable               in   1           Run request.
//  I_pcm_l                in   DATA_WIDTH  Left sample of the pair.
//  I_pcm_r                in   DATA_WIDTH  Right sample of the pair.
//  I_pcm_valid            in   1           Pair valid.
//  O_pcm_ready            out  1           FIFO can accept a pair; a push occurs when valid & ready.
//  I_cs_cfg               in   CS_BITS     Channel-status bits 0..CS_BITS-1; sampled at every block start.
//  I_audio_d_req          in   1           From TX: request audio word.
//  I_validity_bit_req     in   1           From TX: request validity bit.
//  I_user_bit_req         in   1           From TX: request user bit.
//  I_chan_status_bit_req  in   1           From TX: request channel-status bit.
//  I_block_start_flag     in   1           From TX: frame 0 of the block.
//  O_audio_d              out  DATA_WIDTH  To TX I_audio_d.
//  O_validity_bit         out  1           To TX.
//  O_user_bit             out  1           To TX.
//  O_chan_status_bit      out  1           To TX.
//  O_fifo_level           out  log2(D)+1   Number of pairs stored.
//  O_underrun             out  1           One-cycle pulse per muted frame.
//  O_underrun_cnt         out  16          Muted-frame counter; saturates at 0xFFFF.
//  O_running              out  1           High in RUN.
// BEHAVIOUR
//  Reset values: O_audio_d=0, O_validity_bit=1, O_user_bit=USER_BIT_VAL, O_chan_status_bit=0,
//    O_pcm_ready=0, O_fifo_level=0, O_underrun=0, O_underrun_cnt=0, O_running=0.
//  Reset mid-operation flushes the FIFO, the frame index and the latched cs word.
//  Requests are level signals from TX. Only the rising edge, detected with a 1-cycle registered copy, counts as a request.
//  Each output is updated 1 cycle after the edge and held until the next edge of its own request.
//  FSM IDLE:
//    O_pcm_ready=0; outputs driven to 0 / validity 1.
//    Moves to WAIT_BLK when I_enable=1.
//  FSM WAIT_BLK:
//    O_pcm_ready = not full, so the FIFO pre-fills.
//    Outputs behave as in IDLE.
//    On the rising edge of I_block_start_flag: frame index=0, side=LEFT, latch I_cs_cfg, go to RUN.
//    I_enable=0 returns to IDLE.
//  FSM RUN:
//    Audio edge with side=LEFT:
//      FIFO not empty: pop the pair; O_audio_d=L; R held in a pair register; frame valid.
//      FIFO empty: O_audio_d=0; frame muted; O_underrun pulses; cnt+1 (saturating).
//    Audio edge with side=RIGHT: O_audio_d = held R, or 0 if the frame is muted.
//      The frame index then increments and wraps 191->0.
//    The side toggles on every audio edge.
//    Validity edge: O_validity_bit = muted (1 if muted, else 0), for both subframes of the frame.
//    Chan-status edge: bit[frame index] of the latched cs word; 0 for index>=CS_BITS. Same bit for L and R.
//    User edge: O_user_bit = USER_BIT_VAL.
//    Block-start rising edge: resynchronise frame index=0 and side=LEFT, and relatch I_cs_cfg.
//      A TX restart therefore realigns the sequencer.
//    I_enable=0: finish the current frame (through the RIGHT audio edge), then go to IDLE.
//      FIFO contents are retained.
//  FIFO:
//    O_pcm_ready = !full in WAIT_BLK/RUN.
//    Simultaneous push and pop leaves the level unchanged.
//    When full, ready is 0 even if a pop occurs that cycle; ready rises the next cycle.
//    The level counter is exact, from 0 to FIFO_DEPTH.
//  Edges on different request lines in the same cycle are all served in that cycle.
// TESTING
//  T1 Reset:
//    I_rst=1 for 3 clocks.
//    Expect all outputs at their reset values and O_pcm_ready=0.
//  T2 Normal flow:
//    Enable; push 4 pairs (L=0x000001/R=0x800001, then +1 each); pulse block start.
//    Expect O_audio_d sequence 0x000001, 0x800001, 0x000002, 0x800002, ..., validity 0, underrun_cnt 0.
//  T3 Channel status:
//    I_cs_cfg=24'hA5_0003.
//    Over 192 frames expect cs bit 1 at frames 0, 1, 16, 18, 21, 23, otherwise 0; identical for L and R.
//    The index wraps at frame 192.
//  T4 Underrun:
//    Stop pushing after 2 pairs.
//    Frame 3 onward: O_audio_d=0, validity=1, 1 underrun pulse per frame.
//    Resume pushing: the next whole frame is valid.
//  T5 Full/backpressure:
//    Hold I_pcm_valid=1 with no TX requests.
//    Expect O_fifo_level=4 and ready=0; one pop raises ready for 1 push.
//  T6 Resync/disable:
//    Block start mid-block at frame 57: the next audio edge is LEFT with index 0.
//    Drop I_enable mid-frame: the RIGHT word is still sent, then IDLE.
//    O_underrun_cnt forced to 0xFFFF stays at 0xFFFF.

Source files
------------

// File: rtl/spdif_tx_sched_if.sv
// Signal bundle between the audio source / SPDIF TX core and spdif_tx_sched.
// The scheduler takes the slave view; the source/TX side (or a bench) takes the master view.
interface spdif_tx_sched_if #(
   parameter int DATA_WIDTH = 24,
   parameter int FIFO_DEPTH = 4,
   parameter int CS_BITS    = 24
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   // PCM handshake: a pair transfers on every clock where I_pcm_valid && O_pcm_ready.
   // The source keeps I_pcm_l/I_pcm_r stable while valid is high and not yet accepted;
   // O_pcm_ready never depends on I_pcm_valid.
   logic                  I_enable;
   logic [DATA_WIDTH-1:0] I_pcm_l;
   logic [DATA_WIDTH-1:0] I_pcm_r;
   logic                  I_pcm_valid;
   logic                  O_pcm_ready;
   logic [CS_BITS-1:0]    I_cs_cfg;
   logic                  I_audio_d_req;
   logic                  I_validity_bit_req;
   logic                  I_user_bit_req;
   logic                  I_chan_status_bit_req;
   logic                  I_block_start_flag;
   logic [DATA_WIDTH-1:0] O_audio_d;
   logic                  O_validity_bit;
   logic                  O_user_bit;
   logic                  O_chan_status_bit;
   logic [LVL_W-1:0]      O_fifo_level;
   logic                  O_underrun;
   logic [15:0]           O_underrun_cnt;
   logic                  O_running;
   logic [1:0]            O_dbg_state;

   modport slave (
      input  I_enable, I_pcm_l, I_pcm_r, I_pcm_valid, I_cs_cfg,
      input  I_audio_d_req, I_validity_bit_req, I_user_bit_req,
      input  I_chan_status_bit_req, I_block_start_flag,
      output O_pcm_ready, O_audio_d, O_validity_bit, O_user_bit, O_chan_status_bit,
      output O_fifo_level, O_underrun, O_underrun_cnt, O_running, O_dbg_state
   );

   modport master (
      output I_enable, I_pcm_l, I_pcm_r, I_pcm_valid, I_cs_cfg,
      output I_audio_d_req, I_validity_bit_req, I_user_bit_req,
      output I_chan_status_bit_req, I_block_start_flag,
      input  O_pcm_ready, O_audio_d, O_validity_bit, O_user_bit, O_chan_status_bit,
      input  O_fifo_level, O_underrun, O_underrun_cnt, O_running, O_dbg_state
   );
endinterface

// File: rtl/spdif_tx_sched.sv
// SPDIF TX sequencer: buffers stereo PCM pairs and answers the TX core's per-subframe
// requests for audio, validity, user and channel-status bits, muting frames on underrun.
module spdif_tx_sched #(
   parameter int   DATA_WIDTH   = 24,
   parameter int   FIFO_DEPTH   = 4,
   parameter int   CS_BITS      = 24,
   parameter logic USER_BIT_VAL = 1'b0
) (
   input logic             I_clk,
   input logic             I_rst,
   spdif_tx_sched_if.slave bus
);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int LVL_W  = PTR_W + 1;
   localparam int PAIR_W = 2 * DATA_WIDTH;
   localparam logic [7:0] LAST_FRAME = 8'd191;
   localparam int R_AUD = 0;
   localparam int R_VAL = 1;
   localparam int R_USR = 2;
   localparam int R_CS  = 3;
   localparam int R_BLK = 4;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_BLK = 2'd1,
      ST_RUN      = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [4:0]            req_q, req_d, req_rise;
   logic [PAIR_W-1:0]     mem_q [FIFO_DEPTH];
   logic [PAIR_W-1:0]     mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]      level_q, level_d;
   logic                  side_q, side_d, side_eff;
   logic                  muted_q, muted_d;
   logic [7:0]            frame_idx_q, frame_idx_d, idx_eff;
   logic [CS_BITS-1:0]    cs_q, cs_d, cs_eff;
   logic [191:0]          cs_frame;
   logic [DATA_WIDTH-1:0] hold_r_q, hold_r_d, audio_q, audio_d;
   logic                  validity_q, validity_d, user_q, user_d;
   logic                  cs_bit_q, cs_bit_d, underrun_q, underrun_d;
   logic [15:0]           underrun_cnt_q, underrun_cnt_d;
   logic                  full, empty, ready, push, pop;

   always_comb begin
      req_d    = {bus.I_block_start_flag, bus.I_chan_status_bit_req, bus.I_user_bit_req,
                  bus.I_validity_bit_req, bus.I_audio_d_req};
      req_rise = req_d & ~req_q;
      full     = (level_q == LVL_W'(FIFO_DEPTH));
      empty    = (level_q == '0);
      ready    = (state_q != ST_IDLE) && !full;
      push     = bus.I_pcm_valid && ready;
      pop      = 1'b0;

      state_d        = state_q;
      mem_d          = mem_q;
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      side_d         = side_q;
      muted_d        = muted_q;
      frame_idx_d    = frame_idx_q;
      cs_d           = cs_q;
      hold_r_d       = hold_r_q;
      audio_d        = audio_q;
      validity_d     = validity_q;
      user_d         = user_q;
      cs_bit_d       = cs_bit_q;
      underrun_d     = 1'b0;
      underrun_cnt_d = underrun_cnt_q;
      idx_eff        = frame_idx_q;
      side_eff       = side_q;
      cs_eff         = cs_q;
      cs_frame       = '0;

      if (state_q != ST_RUN) begin
         audio_d    = '0;
         validity_d = 1'b1;
         user_d     = USER_BIT_VAL;
         cs_bit_d   = 1'b0;
         muted_d    = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (bus.I_enable) state_d = ST_WAIT_BLK;
         end
         ST_WAIT_BLK: begin
            if (!bus.I_enable) begin
               state_d = ST_IDLE;
            end else if (req_rise[R_BLK]) begin
               frame_idx_d = '0;
               side_d      = 1'b0;
               cs_d        = bus.I_cs_cfg;
               state_d     = ST_RUN;
            end
         end
         ST_RUN: begin
            // A block start is applied first, so requests in the same cycle see the realigned frame.
            if (req_rise[R_BLK]) begin
               idx_eff  = '0;
               side_eff = 1'b0;
               cs_eff   = bus.I_cs_cfg;
            end
            cs_frame    = 192'(cs_eff);
            frame_idx_d = idx_eff;
            side_d      = side_eff;
            cs_d        = cs_eff;
            if (req_rise[R_AUD]) begin
               if (!side_eff) begin
                  if (!empty) begin
                     pop      = 1'b1;
                     audio_d  = mem_q[rd_ptr_q][PAIR_W-1:DATA_WIDTH];
                     hold_r_d = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
                     muted_d  = 1'b0;
                  end else begin
                     audio_d    = '0;
                     muted_d    = 1'b1;
                     underrun_d = 1'b1;
                     if (underrun_cnt_q != 16'hFFFF) underrun_cnt_d = underrun_cnt_q + 16'd1;
                  end
               end else begin
                  audio_d     = muted_q ? '0 : hold_r_q;
                  frame_idx_d = (idx_eff == LAST_FRAME) ? 8'd0 : idx_eff + 8'd1;
               end
               side_d = ~side_eff;
            end
            if (req_rise[R_VAL]) validity_d = muted_d;
            if (req_rise[R_CS])  cs_bit_d   = cs_frame[idx_eff];
            if (req_rise[R_USR]) user_d     = USER_BIT_VAL;
            // Disable only takes effect on a frame boundary so the RIGHT word is never dropped.
            if (!bus.I_enable && !side_d) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (push) begin
         mem_d[wr_ptr_q] = {bus.I_pcm_l, bus.I_pcm_r};
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      level_d = level_q + LVL_W'(push) - LVL_W'(pop);
   end

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state_q        <= ST_IDLE;
         req_q          <= '0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         level_q        <= '0;
         side_q         <= 1'b0;
         muted_q        <= 1'b1;
         frame_idx_q    <= '0;
         cs_q           <= '0;
         hold_r_q       <= '0;
         audio_q        <= '0;
         validity_q     <= 1'b1;
         user_q         <= USER_BIT_VAL;
         cs_bit_q       <= 1'b0;
         underrun_q     <= 1'b0;
         underrun_cnt_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q        <= state_d;
         req_q          <= req_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         level_q        <= level_d;
         side_q         <= side_d;
         muted_q        <= muted_d;
         frame_idx_q    <= frame_idx_d;
         cs_q           <= cs_d;
         hold_r_q       <= hold_r_d;
         audio_q        <= audio_d;
         validity_q     <= validity_d;
         user_q         <= user_d;
         cs_bit_q       <= cs_bit_d;
         underrun_q     <= underrun_d;
         underrun_cnt_q <= underrun_cnt_d;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
      end
   end

   assign bus.O_pcm_ready       = ready;
   assign bus.O_audio_d         = audio_q;
   assign bus.O_validity_bit    = validity_q;
   assign bus.O_user_bit        = user_q;
   assign bus.O_chan_status_bit = cs_bit_q;
   assign bus.O_fifo_level      = level_q;
   assign bus.O_underrun        = underrun_q;
   assign bus.O_underrun_cnt    = underrun_cnt_q;
   assign bus.O_running         = (state_q == ST_RUN);
   assign bus.O_dbg_state       = state_q;
endmodule

// File: tb/tb_spdif_tx_sched.sv
// Directed bench for spdif_tx_sched: reset, normal flow, channel status, underrun,
// backpressure, resync/disable and counter saturation.
module tb_spdif_tx_sched;
   localparam int DW = 24;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   int   exp_cnt = 0;
   logic [DW-1:0] exp_q[$];

   always #5 clk = ~clk;

   spdif_tx_sched_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .CS_BITS(24)) bus ();

   spdif_tx_sched #(
      .DATA_WIDTH(DW), .FIFO_DEPTH(4), .CS_BITS(24), .USER_BIT_VAL(1'b0)
   ) dut (
      .I_clk (clk),
      .I_rst (rst),
      .bus   (bus)
   );

   // ---------------- driver tasks ----------------
   task automatic drive_idle();
      bus.I_enable              = 1'b0;
      bus.I_pcm_l               = '0;
      bus.I_pcm_r               = '0;
      bus.I_pcm_valid           = 1'b0;
      bus.I_cs_cfg              = '0;
      bus.I_audio_d_req         = 1'b0;
      bus.I_validity_bit_req    = 1'b0;
      bus.I_user_bit_req        = 1'b0;
      bus.I_chan_status_bit_req = 1'b0;
      bus.I_block_start_flag    = 1'b0;
   endtask

   task automatic push_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
      bit done = 1'b0;
      @(negedge clk);
      bus.I_pcm_l     = l;
      bus.I_pcm_r     = r;
      bus.I_pcm_valid = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         if (bus.O_pcm_ready === 1'b1) done = 1'b1;
         @(negedge clk);
      end
      bus.I_pcm_valid = 1'b0;
      n_vec++;
      if (!done) begin
         n_err++;
         $display("FAIL push_accept got=0 exp=1 (pair %h/%h)", l, r);
      end
   endtask

   task automatic pulse_block_start();
      @(negedge clk);
      bus.I_block_start_flag = 1'b1;
      @(negedge clk);
      bus.I_block_start_flag = 1'b0;
   endtask

   // One subframe: raise all four requests for a cycle, sample the registered answers.
   task automatic do_subframe(output logic [DW-1:0] aud, output logic vb,
                              output logic cs, output logic und);
      @(negedge clk);
      bus.I_audio_d_req         = 1'b1;
      bus.I_validity_bit_req    = 1'b1;
      bus.I_user_bit_req        = 1'b1;
      bus.I_chan_status_bit_req = 1'b1;
      @(negedge clk);
      aud = bus.O_audio_d;
      vb  = bus.O_validity_bit;
      cs  = bus.O_chan_status_bit;
      und = bus.O_underrun;
      bus.I_audio_d_req         = 1'b0;
      bus.I_validity_bit_req    = 1'b0;
      bus.I_user_bit_req        = 1'b0;
      bus.I_chan_status_bit_req = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_vec++; if (bus.O_audio_d !== 24'h0) begin n_err++; $display("FAIL reset_audio got=%h exp=000000", bus.O_audio_d); end
      n_vec++; if (bus.O_validity_bit !== 1'b1) begin n_err++; $display("FAIL reset_validity got=%b exp=1", bus.O_validity_bit); end
      n_vec++; if (bus.O_user_bit !== 1'b0) begin n_err++; $display("FAIL reset_user got=%b exp=0", bus.O_user_bit); end
      n_vec++; if (bus.O_chan_status_bit !== 1'b0) begin n_err++; $display("FAIL reset_cs got=%b exp=0", bus.O_chan_status_bit); end
      n_vec++; if (bus.O_pcm_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b exp=0", bus.O_pcm_ready); end
      n_vec++; if (bus.O_fifo_level !== 3'd0) begin n_err++; $display("FAIL reset_level got=%0d exp=0", bus.O_fifo_level); end
      n_vec++; if (bus.O_underrun !== 1'b0 || bus.O_underrun_cnt !== 16'h0) begin
         n_err++; $display("FAIL reset_underrun got=%b/%h exp=0/0000", bus.O_underrun, bus.O_underrun_cnt);
      end
      n_vec++; if (bus.O_running !== 1'b0) begin n_err++; $display("FAIL reset_running got=%b exp=0", bus.O_running); end
      rst = 1'b0;
      @(negedge clk);
      n_vec++; if (bus.O_pcm_ready !== 1'b0) begin n_err++; $display("FAIL idle_ready got=%b exp=0", bus.O_pcm_ready); end
   endtask

   task automatic test_normal_flow();
      logic [DW-1:0] aud, exp_w;
      logic vb, cs, und;
      bus.I_cs_cfg = 24'hA50003;
      bus.I_enable = 1'b1;
      @(negedge clk);
      n_vec++; if (bus.O_pcm_ready !== 1'b1 || bus.O_running !== 1'b0) begin
         n_err++; $display("FAIL wait_blk_ready got=%b/%b exp=1/0", bus.O_pcm_ready, bus.O_running);
      end
      for (int i = 0; i < 4; i++) begin
         push_pair(24'h000001 + DW'(i), 24'h800001 + DW'(i));
         exp_q.push_back(24'h000001 + DW'(i));
         exp_q.push_back(24'h800001 + DW'(i));
      end
      n_vec++; if (bus.O_fifo_level !== 3'd4 || bus.O_pcm_ready !== 1'b0) begin
         n_err++; $display("FAIL prefill_full got=%0d/%b exp=4/0", bus.O_fifo_level, bus.O_pcm_ready);
      end
      pulse_block_start();
      n_vec++; if (bus.O_running !== 1'b1) begin n_err++; $display("FAIL run_entry got=%b exp=1", bus.O_running); end
      for (int s = 0; s < 8; s++) begin
         do_subframe(aud, vb, cs, und);
         exp_w = exp_q.pop_front();
         n_vec++; if (aud !== exp_w) begin n_err++; $display("FAIL flow_audio[%0d] got=%h exp=%h", s, aud, exp_w); end
         n_vec++; if (vb !== 1'b0 || und !== 1'b0 || bus.O_user_bit !== 1'b0) begin
            n_err++; $display("FAIL flow_flags[%0d] got=v%b u%b usr%b exp=v0 u0 usr0", s, vb, und, bus.O_user_bit);
         end
      end
      n_vec++; if (bus.O_underrun_cnt !== 16'd0) begin n_err++; $display("FAIL flow_cnt got=%0d exp=0", bus.O_underrun_cnt); end
   endtask

   task automatic test_chan_status();
      logic [DW-1:0] aud;
      logic vb, cs, und, exp_cs;
      pulse_block_start();
      for (int f = 0; f <= 192; f++) begin
         exp_cs = (f == 0 || f == 1 || f == 16 || f == 18 || f == 21 || f == 23 || f == 192);
         do_subframe(aud, vb, cs, und);
         n_vec++; if (cs !== exp_cs || und !== 1'b1 || vb !== 1'b1 || aud !== 24'h0) begin
            n_err++; $display("FAIL cs_left[%0d] got=cs%b u%b v%b a%h exp=cs%b u1 v1 a000000", f, cs, und, vb, aud, exp_cs);
         end
         do_subframe(aud, vb, cs, und);
         n_vec++; if (cs !== exp_cs || vb !== 1'b1 || und !== 1'b0) begin
            n_err++; $display("FAIL cs_right[%0d] got=cs%b v%b u%b exp=cs%b v1 u0", f, cs, vb, und, exp_cs);
         end
         exp_cnt++;
      end
      n_vec++; if (bus.O_underrun_cnt !== 16'(exp_cnt)) begin
         n_err++; $display("FAIL cs_cnt got=%0d exp=%0d", bus.O_underrun_cnt, exp_cnt);
      end
   endtask

   task automatic test_underrun();
      logic [DW-1:0] aud, exp_w;
      logic vb, cs, und, exp_mute;
      push_pair(24'h000010, 24'h000020);
      push_pair(24'h000011, 24'h000021);
      exp_q.push_back(24'h000010); exp_q.push_back(24'h000020);
      exp_q.push_back(24'h000011); exp_q.push_back(24'h000021);
      repeat (4) exp_q.push_back(24'h0);
      for (int fr = 0; fr < 4; fr++) begin
         exp_mute = (fr >= 2);
         do_subframe(aud, vb, cs, und);
         exp_w = exp_q.pop_front();
         n_vec++; if (aud !== exp_w || vb !== exp_mute || und !== exp_mute) begin
            n_err++; $display("FAIL und_left[%0d] got=a%h v%b u%b exp=a%h v%b u%b", fr, aud, vb, und, exp_w, exp_mute, exp_mute);
         end
         do_subframe(aud, vb, cs, und);
         exp_w = exp_q.pop_front();
         n_vec++; if (aud !== exp_w || vb !== exp_mute || und !== 1'b0) begin
            n_err++; $display("FAIL und_right[%0d] got=a%h v%b u%b exp=a%h v%b u0", fr, aud, vb, und, exp_w, exp_mute);
         end
      end
      exp_cnt += 2;
      push_pair(24'h000012, 24'h000022);
      do_subframe(aud, vb, cs, und);
      n_vec++; if (aud !== 24'h000012 || vb !== 1'b0 || und !== 1'b0) begin
         n_err++; $display("FAIL resume_left got=a%h v%b u%b exp=a000012 v0 u0", aud, vb, und);
      end
      do_subframe(aud, vb, cs, und);
      n_vec++; if (aud !== 24'h000022 || vb !== 1'b0) begin
         n_err++; $display("FAIL resume_right got=a%h v%b exp=a000022 v0", aud, vb);
      end
      n_vec++; if (bus.O_underrun_cnt !== 16'(exp_cnt)) begin
         n_err++; $display("FAIL und_cnt got=%0d exp=%0d", bus.O_underrun_cnt, exp_cnt);
      end
   endtask

   task automatic test_full();
      logic [DW-1:0] aud, exp_w;
      logic vb, cs, und;
      for (int i = 0; i < 4; i++) push_pair(24'h000100 + DW'(i), 24'h000200 + DW'(i));
      bus.I_pcm_l     = 24'h0001FF;
      bus.I_pcm_r     = 24'h0002FF;
      bus.I_pcm_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         n_vec++; if (bus.O_fifo_level !== 3'd4 || bus.O_pcm_ready !== 1'b0) begin
            n_err++; $display("FAIL full_hold[%0d] got=%0d/%b exp=4/0", c, bus.O_fifo_level, bus.O_pcm_ready);
         end
         @(negedge clk);
      end
      do_subframe(aud, vb, cs, und);
      n_vec++; if (aud !== 24'h000100 || bus.O_fifo_level !== 3'd3 || bus.O_pcm_ready !== 1'b1) begin
         n_err++; $display("FAIL full_pop got=a%h l%0d r%b exp=a000100 l3 r1", aud, bus.O_fifo_level, bus.O_pcm_ready);
      end
      @(negedge clk);
      n_vec++; if (bus.O_fifo_level !== 3'd4 || bus.O_pcm_ready !== 1'b0) begin
         n_err++; $display("FAIL full_refill got=%0d/%b exp=4/0", bus.O_fifo_level, bus.O_pcm_ready);
      end
      bus.I_pcm_valid = 1'b0;
      exp_q.push_back(24'h000200);
      for (int i = 1; i < 4; i++) begin
         exp_q.push_back(24'h000100 + DW'(i));
         exp_q.push_back(24'h000200 + DW'(i));
      end
      exp_q.push_back(24'h0001FF);
      exp_q.push_back(24'h0002FF);
      for (int s = 0; s < 9; s++) begin
         do_subframe(aud, vb, cs, und);
         exp_w = exp_q.pop_front();
         n_vec++; if (aud !== exp_w || vb !== 1'b0) begin
            n_err++; $display("FAIL full_drain[%0d] got=a%h v%b exp=a%h v0", s, aud, vb, exp_w);
         end
      end
      n_vec++; if (bus.O_fifo_level !== 3'd0) begin n_err++; $display("FAIL full_empty got=%0d exp=0", bus.O_fifo_level); end
   endtask

   task automatic test_resync_disable();
      logic [DW-1:0] aud;
      logic vb, cs, und;
      pulse_block_start();
      for (int f = 0; f < 57; f++) begin
         do_subframe(aud, vb, cs, und);
         do_subframe(aud, vb, cs, und);
         exp_cnt++;
      end
      do_subframe(aud, vb, cs, und);
      exp_cnt++;
      n_vec++; if (und !== 1'b1) begin n_err++; $display("FAIL f57_underrun got=%b exp=1", und); end
      push_pair(24'h000AAA, 24'h000BBB);
      push_pair(24'h000CCC, 24'h000DDD);
      push_pair(24'h000EEE, 24'h000FFF);
      bus.I_cs_cfg = 24'h000002;
      pulse_block_start();
      do_subframe(aud, vb, cs, und);
      n_vec++; if (aud !== 24'h000AAA || cs !== 1'b0 || vb !== 1'b0) begin
         n_err++; $display("FAIL resync_left got=a%h cs%b v%b exp=a000AAA cs0 v0", aud, cs, vb);
      end
      do_subframe(aud, vb, cs, und);
      n_vec++; if (aud !== 24'h000BBB || cs !== 1'b0) begin
         n_err++; $display("FAIL resync_right got=a%h cs%b exp=a000BBB cs0", aud, cs);
      end
      do_subframe(aud, vb, cs, und);
      n_vec++; if (aud !== 24'h000CCC || cs !== 1'b1) begin
         n_err++; $display("FAIL resync_f1 got=a%h cs%b exp=a000CCC cs1", aud, cs);
      end
      bus.I_enable = 1'b0;
      @(negedge clk);
      n_vec++; if (bus.O_running !== 1'b1) begin n_err++; $display("FAIL drain_running got=%b exp=1", bus.O_running); end
      do_subframe(aud, vb, cs, und);
      n_vec++; if (aud !== 24'h000DDD || cs !== 1'b1) begin
         n_err++; $display("FAIL drain_right got=a%h cs%b exp=a000DDD cs1", aud, cs);
      end
      @(negedge clk);
      n_vec++; if (bus.O_running !== 1'b0 || bus.O_audio_d !== 24'h0 || bus.O_validity_bit !== 1'b1) begin
         n_err++; $display("FAIL idle_outputs got=r%b a%h v%b exp=r0 a000000 v1", bus.O_running, bus.O_audio_d, bus.O_validity_bit);
      end
      n_vec++; if (bus.O_fifo_level !== 3'd1) begin n_err++; $display("FAIL idle_retain got=%0d exp=1", bus.O_fifo_level); end
      n_vec++; if (bus.O_underrun_cnt !== 16'(exp_cnt)) begin
         n_err++; $display("FAIL resync_cnt got=%0d exp=%0d", bus.O_underrun_cnt, exp_cnt);
      end
      // Saturation: preload the counter, then produce one more muted frame.
      force dut.underrun_cnt_q = 16'hFFFF;
      @(negedge clk);
      release dut.underrun_cnt_q;
      bus.I_enable = 1'b1;
      @(negedge clk);
      pulse_block_start();
      do_subframe(aud, vb, cs, und);
      n_vec++; if (aud !== 24'h000EEE || vb !== 1'b0) begin
         n_err++; $display("FAIL restart_left got=a%h v%b exp=a000EEE v0", aud, vb);
      end
      do_subframe(aud, vb, cs, und);
      do_subframe(aud, vb, cs, und);
      n_vec++; if (und !== 1'b1 || bus.O_underrun_cnt !== 16'hFFFF) begin
         n_err++; $display("FAIL sat_cnt got=u%b c%h exp=u1 cFFFF", und, bus.O_underrun_cnt);
      end
      do_subframe(aud, vb, cs, und);
   endtask

   initial begin
      drive_idle();
      test_reset();
      test_normal_flow();
      test_chan_status();
      test_underrun();
      test_full();
      test_resync_disable();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      n_err++;
      $display("FAIL watchdog got=timeout exp=completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "watchdog expired");
   end
endmodule
